soc_system_pio_event_fifo: RTL
==============================

# soc_system_pio_event_fifo

Parametrised Avalon-MM input PIO that supersedes the fixed-width edge-capture PIOs on the HPS lightweight bridge, e.g. DDC tail status. It adds a configurable synchroniser depth, per-bit rising/falling edge selection and write-1-to-clear capture bits. It also adds an event FIFO that records a snapshot of the input plus a free-running timestamp for every qualifying edge, so software can reconstruct edge ordering without polling.

## Interface
- WIDTH, 14, input port width, 1..32
- SYNC_STAGES, 2, synchroniser flops ahead of edge detection, >=2
- FIFO_DEPTH, 16, event FIFO entries, power of 2, 2..256
- TS_WIDTH, 32, timestamp counter width, 1..32

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe, used only for FIFO pop
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous input pins
- readdata  out  32  registered read data, read latency 1
- irq  out  1  level interrupt

## Operation
- Sync chain: in_port passes SYNC_STAGES flops to give data_in, then one more flop to give prev. rise = data_in & ~prev, fall = ~data_in & prev.
- edge_detect = (rise & RISE_EN) | (fall & FALL_EN).
- Registers (word address): 0 DATA (RO, data_in); 1 RISE_EN (RW, reset all-ones); 2 IRQ_MASK (RW, reset 0); 3 EDGE_CAPTURE (read; write 1 clears that bit); 4 FALL_EN (RW, reset 0); 5 FIFO_STATUS; 6 EVT_DATA (RO, head snapshot); 7 EVT_TS (RO, head timestamp, read pops).
- FIFO_STATUS read: [8:0] count, [16] empty, [17] full, [18] overflow (sticky), [31] fifo_irq_en. A write updates [31] from writedata[31]. A write with writedata[18]=1 clears overflow.
- Unused upper bits read 0. Writes to read-only addresses are ignored.
- EDGE_CAPTURE: a bit sets when its edge_detect bit is 1. It clears on a write with that writedata bit 1. If set and clear hit the same bit in the same cycle, set wins.
- Timestamp: free-running TS_WIDTH counter, reset 0, increments every cycle, wraps to 0 without a flag.
- Push: in any cycle with |edge_detect, push {ts, data_in} as one entry. Multiple bits edging in the same cycle produce one entry.
- Pop: chipselect & ~read_n & address==7 with count>0. The pop on an empty FIFO is ignored.
- Full: a push while full without a concurrent pop drops the entry and sets overflow; FIFO contents stay unchanged. A push and pop in the same cycle while full are both accepted: count stays, no overflow.
- irq = |(EDGE_CAPTURE & IRQ_MASK) | (fifo_irq_en & ~empty).

## Timing
- Reset values: readdata=0, irq=0, all capture/sync/FIFO state 0, RISE_EN all-ones, ts=0.
- Input to EDGE_CAPTURE set: an in_port transition sampled at edge N sets EDGE_CAPTURE after edge N+SYNC_STAGES. irq follows combinationally in the same cycle.
- If in_port is high at reset release, a rising edge registers SYNC_STAGES cycles later. This is intended.
- readdata is loaded every cycle from the register mux at the current address, independent of chipselect. The value appears the cycle after the address is presented.
- A pop read returns the head entry current at the read cycle. Count decrements at that same edge, so the next read of 6/7 shows the new head.
- EVT_DATA for a given entry must be read before EVT_TS; the team driver does this.
- The push is written at the edge after edge_detect. Count and empty update that edge. The entry is readable at the following read.
- Entry timestamp is the ts value in the cycle edge_detect was high.
- Register writes take effect at the write edge. A write to RISE_EN/FALL_EN affects edge_detect in the next cycle.
- Asserting reset_n low mid-operation clears everything immediately (async). Partial reads are lost.

## Test plan
- WIDTH=14 defaults: drive in_port 0->0x0001 -> EDGE_CAPTURE=0x0001 after 2+1 cycles; FIFO count=1; EVT_DATA=0x0001; EVT_TS = cycle of detect; after EVT_TS read, count=0 and empty=1.
- FALL_EN=0x0002, RISE_EN=0: toggle bit1 high then low -> exactly one entry with EVT_DATA bit1=0; a rising edge produces no capture.
- IRQ_MASK=0x0004, edge on bit2 -> irq=1. Write 0x0004 to addr 3 -> irq=0. Write coincident with a new edge on bit2 -> bit stays 1.
- FIFO_DEPTH=4: 6 separated rising edges with no pops -> count=4, full=1, overflow=1, entries hold edges 1-4. Write FIFO_STATUS bit18 -> overflow=0.
- Full FIFO, pop and edge in the same cycle -> count stays 4, overflow stays 0, newest entry at tail.
- TS_WIDTH=4: edges 20 cycles apart -> timestamps differ by 20 mod 16. Assert reset_n low mid-stream -> readdata=0, irq=0, count=0, RISE_EN=all-ones.

Source files
------------

// File: rtl/soc_system_pio_event_fifo.sv
// Avalon-MM input PIO with synchronised edge capture, per-bit edge selection,
// W1C capture bits and a timestamped event FIFO for edge-order reconstruction.
module soc_system_pio_event_fifo #(
  parameter int WIDTH       = 14,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int TS_WIDTH    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = 9;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]    prev_q, data_in, edge_detect;
  logic [WIDTH-1:0]    rise_en_q, fall_en_q, irq_mask_q, cap_q, cap_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH-1:0]    mem_data_q [FIFO_DEPTH];
  logic [TS_WIDTH-1:0] mem_ts_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, fifo_irq_en_q;
  logic [31:0]         readdata_q, readdata_d;
  logic                wr_sel, push, pop, push_ok, full, empty;
  logic                unused_wdata;

  assign data_in     = sync_q[SYNC_STAGES-1];
  assign edge_detect = (data_in & ~prev_q & rise_en_q) | (~data_in & prev_q & fall_en_q);

  assign wr_sel  = chipselect & ~write_n;
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push    = |edge_detect;
  assign pop     = chipselect & ~read_n & (address == 3'd7) & ~empty;
  // A push into a full FIFO is only accepted when a pop frees the head slot.
  assign push_ok = push & (~full | pop);
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      ts_q   <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= data_in;
      ts_q   <= ts_q + TS_WIDTH'(1);
    end
  end

  // Set has priority over a simultaneous write-1-to-clear.
  assign cap_d = (cap_q & ~((wr_sel && address == 3'd3) ? writedata[WIDTH-1:0] : '0))
               | edge_detect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_en_q     <= '1;
      fall_en_q     <= '0;
      irq_mask_q    <= '0;
      cap_q         <= '0;
      fifo_irq_en_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      cap_q <= cap_d;
      if (wr_sel) begin
        case (address)
          3'd1: rise_en_q  <= writedata[WIDTH-1:0];
          3'd2: irq_mask_q <= writedata[WIDTH-1:0];
          3'd4: fall_en_q  <= writedata[WIDTH-1:0];
          3'd5: fifo_irq_en_q <= writedata[31];
          default: ;
        endcase
      end
      if (push & full & ~pop)                         ovf_q <= 1'b1;
      else if (wr_sel && address == 3'd5 && writedata[18]) ovf_q <= 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_ts_q[i]   <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_data_q[wr_ptr_q] <= data_in;
        mem_ts_q[wr_ptr_q]   <= ts_q;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0: readdata_d[WIDTH-1:0] = data_in;
      3'd1: readdata_d[WIDTH-1:0] = rise_en_q;
      3'd2: readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3: readdata_d[WIDTH-1:0] = cap_q;
      3'd4: readdata_d[WIDTH-1:0] = fall_en_q;
      3'd5: begin
        readdata_d[8:0] = count_q;
        readdata_d[16]  = empty;
        readdata_d[17]  = full;
        readdata_d[18]  = ovf_q;
        readdata_d[31]  = fifo_irq_en_q;
      end
      3'd6: readdata_d[WIDTH-1:0]    = mem_data_q[rd_ptr_q];
      default: readdata_d[TS_WIDTH-1:0] = mem_ts_q[rd_ptr_q];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = (|(cap_q & irq_mask_q)) | (fifo_irq_en_q & ~empty);

endmodule
